// File: rtl/sub_parser_seq.sv
// -----------------------------------------------------------------------------
// sub_parser_seq
// Sequential field extractor. Accepts one packet header vector plus a list of
// parse actions, applies the actions one per cycle (each copies a 2B/4B/6B
// field from a byte offset of the header into a PHV container), then presents
// the assembled container vector downstream with a valid/ready handshake.
//
// Ports
//   clk               clock, all logic on the rising edge
//   rst               synchronous active-high reset
//   hdr_vec_in        header bytes, byte k at [8k+7:8k]
//   parse_actions_in  action k at [16k+15:16k]
//   hdr_valid_in      header/actions valid
//   hdr_ready_out     block can accept (IDLE only)
//   phv_out           assembled containers (2B @0, 4B @128, 6B @384)
//   parse_err_out     at least one action was out of range
//   phv_valid_out     phv_out/parse_err_out valid
//   phv_ready_in      downstream accepts phv_out
// -----------------------------------------------------------------------------
module sub_parser_seq #(
    parameter int C_HDR_WIDTH      = 1024,
    parameter int C_NUM_ACTIONS    = 10,
    parameter int C_ACTION_WIDTH   = 16,
    parameter int C_PHV_CONT_WIDTH = 768
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [C_HDR_WIDTH-1:0]                  hdr_vec_in,
    input  logic [C_NUM_ACTIONS*C_ACTION_WIDTH-1:0] parse_actions_in,
    input  logic                                    hdr_valid_in,
    output logic                                    hdr_ready_out,
    output logic [C_PHV_CONT_WIDTH-1:0]             phv_out,
    output logic                                    parse_err_out,
    output logic                                    phv_valid_out,
    input  logic                                    phv_ready_in
);

    localparam int C_HDR_BYTES = C_HDR_WIDTH / 8;
    localparam int C_IDX_W     = $clog2(C_NUM_ACTIONS + 1);
    localparam logic [C_IDX_W-1:0] C_IDX_END = C_IDX_W'(C_NUM_ACTIONS);
    localparam int C_NUM_CONT  = 8;
    localparam int C_BASE_4B   = 128;
    localparam int C_BASE_6B   = 384;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXTRACT,
        ST_OUTPUT
    } state_t;

    state_t                        state_reg, state_next;
    logic [C_IDX_W-1:0]            idx_reg, idx_next;
    logic                          act_vld_reg, act_vld_next;
    logic [C_PHV_CONT_WIDTH-1:0]   phv_reg, phv_next;
    logic                          err_reg, err_next;
    logic                          hdr_load;
    logic                          fetch_en;

    // Latched header and action list; the action list is read through a
    // registered port, so each action is applied the cycle after it is fetched.
    logic [C_HDR_WIDTH-1:0]        hdr_reg;
    logic [C_ACTION_WIDTH-1:0]     act_mem [C_NUM_ACTIONS];
    logic [C_ACTION_WIDTH-1:0]     act_reg;
    logic [C_ACTION_WIDTH-1:0]     act_in  [C_NUM_ACTIONS];

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_ACTIONS; gi++) begin : g_unpack
            assign act_in[gi] = parse_actions_in[gi*C_ACTION_WIDTH +: C_ACTION_WIDTH];
        end
    endgenerate

    // ---------------- action decode ----------------
    logic [6:0]  act_offset;
    logic [1:0]  act_type;
    logic [2:0]  act_cont;
    logic        act_en;
    logic [8:0]  act_end_byte;
    logic        act_in_range;
    logic        do_write;
    logic        err_set;
    logic [47:0] field;
    logic [C_HDR_WIDTH+47:0] hdr_pad;
    logic        unused_rsvd;

    assign act_offset   = act_reg[12:6];
    assign act_type     = act_reg[5:4];
    assign act_cont     = act_reg[3:1];
    assign unused_rsvd  = &{1'b0, act_reg[15:13]};
    assign act_en       = act_vld_reg && act_reg[0] && (act_type != 2'b00);
    // Field length in bytes is twice the type code (2/4/6).
    assign act_end_byte = 9'(act_offset) + 9'({act_type, 1'b0});
    assign act_in_range = (act_end_byte <= 9'(C_HDR_BYTES));
    assign do_write     = act_en && act_in_range;
    assign err_set      = act_en && !act_in_range;

    // Zero padding keeps the 48-bit window in bounds for offsets near the
    // end of the header; only the low 2B/4B are used for narrower fields.
    assign hdr_pad = {48'd0, hdr_reg};
    assign field   = hdr_pad[{act_offset, 3'b000} +: 48];

    logic [C_NUM_CONT-1:0] we2, we4, we6;
    generate
        for (gi = 0; gi < C_NUM_CONT; gi++) begin : g_we
            assign we2[gi] = do_write && (act_type == 2'b01) && (act_cont == 3'(gi));
            assign we4[gi] = do_write && (act_type == 2'b10) && (act_cont == 3'(gi));
            assign we6[gi] = do_write && (act_type == 2'b11) && (act_cont == 3'(gi));
        end
    endgenerate

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            act_vld_reg <= 1'b0;
            phv_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            act_vld_reg <= act_vld_next;
            phv_reg     <= phv_next;
            err_reg     <= err_next;
        end
    end

    // Data storage needs no reset: it is only consumed after a fresh load.
    always_ff @(posedge clk) begin
        if (hdr_load) begin
            hdr_reg <= hdr_vec_in;
            for (int k = 0; k < C_NUM_ACTIONS; k++) begin
                act_mem[k] <= act_in[k];
            end
        end
        if (fetch_en) begin
            act_reg <= act_mem[idx_reg];
        end
    end

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        act_vld_next = act_vld_reg;
        phv_next     = phv_reg;
        err_next     = err_reg;
        hdr_load     = 1'b0;
        fetch_en     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (hdr_valid_in) begin
                    hdr_load     = 1'b1;
                    phv_next     = '0;
                    err_next     = 1'b0;
                    idx_next     = '0;
                    act_vld_next = 1'b0;
                    state_next   = ST_EXTRACT;
                end
            end

            ST_EXTRACT: begin
                // Apply the action fetched last cycle; in-order application
                // makes the highest index win on a shared container.
                for (int i = 0; i < C_NUM_CONT; i++) begin
                    if (we2[i]) phv_next[16*i +: 16]             = field[15:0];
                    if (we4[i]) phv_next[C_BASE_4B+32*i +: 32]   = field[31:0];
                    if (we6[i]) phv_next[C_BASE_6B+48*i +: 48]   = field;
                end
                if (err_set) begin
                    err_next = 1'b1;
                end

                if (idx_reg < C_IDX_END) begin
                    fetch_en     = 1'b1;
                    idx_next     = idx_reg + C_IDX_W'(1);
                    act_vld_next = 1'b1;
                end else begin
                    // Last fetched action is applied on this edge.
                    idx_next     = '0;
                    act_vld_next = 1'b0;
                    state_next   = ST_OUTPUT;
                end
            end

            ST_OUTPUT: begin
                if (phv_ready_in) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign hdr_ready_out = (state_reg == ST_IDLE);
    assign phv_valid_out = (state_reg == ST_OUTPUT);
    assign phv_out       = phv_reg;
    assign parse_err_out = err_reg;

endmodule

// File: tb/tb_sub_parser_seq.sv
module tb_sub_parser_seq;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] hdr_vec_in;
    logic [159:0]  parse_actions_in;
    logic          hdr_valid_in;
    logic          hdr_ready_out;
    logic [767:0]  phv_out;
    logic          parse_err_out;
    logic          phv_valid_out;
    logic          phv_ready_in;

    int n_tests = 0;
    int n_fail  = 0;

    sub_parser_seq dut (
        .clk              (clk),
        .rst              (rst),
        .hdr_vec_in       (hdr_vec_in),
        .parse_actions_in (parse_actions_in),
        .hdr_valid_in     (hdr_valid_in),
        .hdr_ready_out    (hdr_ready_out),
        .phv_out          (phv_out),
        .parse_err_out    (parse_err_out),
        .phv_valid_out    (phv_valid_out),
        .phv_ready_in     (phv_ready_in)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk_act(input int off, input int typ, input int ci);
        return {3'b000, 7'(off), 2'(typ), 3'(ci), 1'b1};
    endfunction

    function automatic logic [1023:0] ramp_hdr();
        logic [1023:0] h;
        for (int k = 0; k < 128; k++) h[8*k +: 8] = 8'(k);
        return h;
    endfunction

    // Waits (bounded) for IDLE, presents a header for one accept edge, then
    // scrambles the inputs so any late sampling would corrupt the result.
    task automatic send_hdr(input string tag, input logic [1023:0] h, input logic [159:0] a);
        int n = 0;
        while (!hdr_ready_out && n < 40) begin tick(); n++; end
        check({tag, "_ready_before_accept"}, 768'(hdr_ready_out), 768'(1));
        hdr_vec_in       = h;
        parse_actions_in = a;
        hdr_valid_in     = 1'b1;
        tick();
        hdr_valid_in     = 1'b0;
        hdr_vec_in       = '1;
        parse_actions_in = '1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!phv_valid_out && n < 40) begin tick(); n++; end
    endtask

    task automatic deliver();
        phv_ready_in = 1'b1;
        tick();
        phv_ready_in = 1'b0;
    endtask

    logic [1023:0] hdr;
    logic [159:0]  acts;
    logic [767:0]  exp_phv;
    logic [767:0]  exp_b;
    int            lat;

    initial begin
        rst              = 1'b1;
        hdr_vec_in       = '0;
        parse_actions_in = '0;
        hdr_valid_in     = 1'b0;
        phv_ready_in     = 1'b0;
        tick();
        tick();
        check("reset_ready", 768'(hdr_ready_out), 768'(1));
        check("reset_valid", 768'(phv_valid_out), 768'(0));
        check("reset_phv",   phv_out,             768'(0));
        check("reset_err",   768'(parse_err_out), 768'(0));
        rst = 1'b0;
        tick();

        // ---- single 2B extract + latency ----
        hdr = ramp_hdr();
        hdr[96 +: 8]  = 8'h08;
        hdr[104 +: 8] = 8'h00;
        acts = '0;
        acts[15:0] = mk_act(12, 1, 3);
        send_hdr("t1", hdr, acts);
        check("t1_busy_ready", 768'(hdr_ready_out), 768'(0));
        wait_valid(lat);
        check("t1_latency", 768'(lat), 768'(11));
        exp_phv = '0;
        exp_phv[63:48] = 16'h0008;
        check("t1_phv", phv_out, exp_phv);
        check("t1_err", 768'(parse_err_out), 768'(0));
        deliver();
        check("t1_post_valid", 768'(phv_valid_out), 768'(0));
        check("t1_post_ready", 768'(hdr_ready_out), 768'(1));
        $display("[TB] t1 single 2B extract done");

        // ---- mixed widths ----
        hdr = ramp_hdr();
        acts = '0;
        acts[15:0]  = mk_act(0, 3, 0);
        acts[31:16] = mk_act(26, 2, 7);
        acts[47:32] = mk_act(126, 1, 0);
        send_hdr("t2", hdr, acts);
        wait_valid(lat);
        check("t2_latency", 768'(lat), 768'(11));
        exp_phv = '0;
        exp_phv[431:384] = 48'h050403020100;
        exp_phv[383:352] = 32'h1d1c1b1a;
        exp_phv[15:0]    = 16'h7f7e;
        check("t2_phv", phv_out, exp_phv);
        check("t2_err", 768'(parse_err_out), 768'(0));
        deliver();
        $display("[TB] t2 mixed widths done");

        // ---- out-of-range and overwrite ----
        hdr = ramp_hdr();
        acts = '0;
        acts[15:0]  = mk_act(126, 2, 0);
        acts[31:16] = mk_act(0, 1, 1);
        acts[47:32] = mk_act(2, 1, 1);
        send_hdr("t3", hdr, acts);
        wait_valid(lat);
        check("t3_valid", 768'(phv_valid_out), 768'(1));
        exp_phv = '0;
        exp_phv[31:16] = 16'h0302;
        check("t3_phv", phv_out, exp_phv);
        check("t3_4b_zero", 768'(phv_out[383:128]), 768'(0));
        check("t3_err", 768'(parse_err_out), 768'(1));
        deliver();
        $display("[TB] t3 out-of-range and overwrite done");

        // ---- backpressure, ignored pulses, back-to-back ----
        hdr = ramp_hdr();
        acts = '0;
        acts[15:0] = mk_act(4, 2, 2);
        send_hdr("t4a", hdr, acts);
        tick();
        tick();
        hdr_vec_in       = '1;
        parse_actions_in = {10{mk_act(0, 1, 5)}};
        hdr_valid_in     = 1'b1;
        check("t4_extract_ready", 768'(hdr_ready_out), 768'(0));
        tick();
        hdr_valid_in = 1'b0;
        wait_valid(lat);
        check("t4_valid", 768'(phv_valid_out), 768'(1));
        exp_phv = '0;
        exp_phv[223:192] = 32'h07060504;
        check("t4_phv", phv_out, exp_phv);
        for (int i = 0; i < 5; i++) begin
            hdr_valid_in = i[0];
            tick();
            check("t4_stall_phv",   phv_out,             exp_phv);
            check("t4_stall_valid", 768'(phv_valid_out), 768'(1));
            check("t4_stall_ready", 768'(hdr_ready_out), 768'(0));
        end
        // Second header waits with valid high through the handshake edge.
        hdr = ramp_hdr();
        acts = '0;
        acts[15:0] = mk_act(10, 1, 7);
        hdr_vec_in       = hdr;
        parse_actions_in = acts;
        hdr_valid_in     = 1'b1;
        phv_ready_in     = 1'b1;
        tick();
        phv_ready_in = 1'b0;
        check("t4_hs_valid", 768'(phv_valid_out), 768'(0));
        check("t4_hs_ready", 768'(hdr_ready_out), 768'(1));
        tick();
        hdr_valid_in     = 1'b0;
        hdr_vec_in       = '1;
        parse_actions_in = '1;
        check("t4_b2b_accepted", 768'(hdr_ready_out), 768'(0));
        wait_valid(lat);
        check("t4_b2b_latency", 768'(lat), 768'(11));
        exp_b = '0;
        exp_b[127:112] = 16'h0b0a;
        check("t4_b2b_phv", phv_out, exp_b);
        check("t4_b2b_err", 768'(parse_err_out), 768'(0));
        deliver();
        check("t4_one_phv", 768'(phv_valid_out), 768'(0));
        $display("[TB] t4 backpressure and back-to-back done");

        // ---- reset mid-EXTRACT ----
        hdr = ramp_hdr();
        acts = '0;
        acts[15:0]  = mk_act(126, 2, 0);
        acts[31:16] = mk_act(0, 1, 4);
        send_hdr("t5a", hdr, acts);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_valid", 768'(phv_valid_out), 768'(0));
        check("t5_rst_phv",   phv_out,             768'(0));
        check("t5_rst_ready", 768'(hdr_ready_out), 768'(1));
        check("t5_rst_err",   768'(parse_err_out), 768'(0));
        acts = '0;
        acts[15:0] = mk_act(100, 3, 3);
        send_hdr("t5b", hdr, acts);
        wait_valid(lat);
        check("t5_latency", 768'(lat), 768'(11));
        exp_phv = '0;
        exp_phv[575:528] = 48'h696867666564;
        check("t5_phv", phv_out, exp_phv);
        check("t5_err", 768'(parse_err_out), 768'(0));
        deliver();
        $display("[TB] t5 reset mid-extract done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
